regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 133 +++++++++++++
 tb/tb_regfile_mp.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports, two combinational read ports, optional
// write-to-read bypass and a post-reset clear sweep gated by a Ready handshake.
module regfile_mp #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREG      = 32,
    parameter int unsigned AW        = $clog2(NREG),
    parameter bit          ZERO_REG  = 1'b1,
    parameter bit          BYPASS    = 1'b1,
    parameter bit          INIT_MODE = 1'b0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            RegW0,
    input  logic [AW-1:0]   DR0,
    input  logic [XLEN-1:0] Reg_In0,
    input  logic            RegW1,
    input  logic [AW-1:0]   DR1,
    input  logic [XLEN-1:0] Reg_In1,
    input  logic [AW-1:0]   SR1,
    input  logic [AW-1:0]   SR2,
    output logic [XLEN-1:0] ReadReg1,
    output logic [XLEN-1:0] ReadReg2,
    output logic            Ready
);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e          state_q;
    logic [AW:0]     clr_idx_q;
    logic [AW:0]     clr_idx_d;
    logic            ready_q;
    logic [XLEN-1:0] mem_q [NREG];

    logic            run;
    logic            sweep_last;
    logic [AW-1:0]   clr_addr;
    logic [XLEN-1:0] init_val;
    logic            we0;
    logic            we1;

    assign run        = (state_q == StRun);
    assign clr_addr   = clr_idx_q[AW-1:0];
    assign clr_idx_d  = clr_idx_q + {{AW{1'b0}}, 1'b1};
    assign sweep_last = (clr_idx_q == (AW+1)'(NREG - 1));

    // Entry 0 writes are dropped entirely when it is hardwired, including for bypass.
    assign we0 = run && RegW0 && !(ZERO_REG && (DR0 == '0));
    assign we1 = run && RegW1 && !(ZERO_REG && (DR1 == '0));

    always_comb begin
        init_val = '0;
        if (INIT_MODE) begin
            init_val = XLEN'(clr_addr);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    clr_idx_q <= clr_idx_d;
                    if (sweep_last) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    state_q <= StRun;
                end
                default: begin
                    state_q <= StClear;
                end
            endcase
        end
    end

    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_q == StClear) begin
                mem_q[clr_addr] <= init_val;
            end else begin
                if (we0) begin
                    mem_q[DR0] <= Reg_In0;
                end
                if (we1) begin
                    mem_q[DR1] <= Reg_In1;
                end
            end
        end
    end

    function automatic logic [XLEN-1:0] rd_sel(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored,
        input logic            run_i,
        input logic            w0_i,
        input logic [AW-1:0]   a0_i,
        input logic [XLEN-1:0] d0_i,
        input logic            w1_i,
        input logic [AW-1:0]   a1_i,
        input logic [XLEN-1:0] d1_i
    );
        logic [XLEN-1:0] val;
        val = stored;
        if (BYPASS) begin
            if (w1_i && (a1_i == addr)) begin
                val = d1_i;
            end else if (w0_i && (a0_i == addr)) begin
                val = d0_i;
            end
        end
        if (!run_i || (ZERO_REG && (addr == '0))) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        ReadReg1 = rd_sel(SR1, mem_q[SR1], run, we0, DR0, Reg_In0, we1, DR1, Reg_In1);
    end

    always_comb begin
        ReadReg2 = rd_sel(SR2, mem_q[SR2], run, we0, DR0, Reg_In0, we1, DR1, Reg_In1);
    end

    assign Ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing/zero-init instance and one
// non-bypassing/index-init instance share the same stimulus.
module tb_regfile_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            regw0;
    logic [AW-1:0]   dr0;
    logic [XLEN-1:0] reg_in0;
    logic            regw1;
    logic [AW-1:0]   dr1;
    logic [XLEN-1:0] reg_in1;
    logic [AW-1:0]   sr1;
    logic [AW-1:0]   sr2;

    logic [XLEN-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic            a_ready, b_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // dut_a: BYPASS=1, INIT_MODE=0
    regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .ZERO_REG(1'b1), .BYPASS(1'b1), .INIT_MODE(1'b0)
    ) dut_a (
        .CLK(clk), .RST(rst),
        .RegW0(regw0), .DR0(dr0), .Reg_In0(reg_in0),
        .RegW1(regw1), .DR1(dr1), .Reg_In1(reg_in1),
        .SR1(sr1), .SR2(sr2),
        .ReadReg1(a_rd1), .ReadReg2(a_rd2), .Ready(a_ready)
    );

    // dut_b: BYPASS=0, INIT_MODE=1
    regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .ZERO_REG(1'b1), .BYPASS(1'b0), .INIT_MODE(1'b1)
    ) dut_b (
        .CLK(clk), .RST(rst),
        .RegW0(regw0), .DR0(dr0), .Reg_In0(reg_in0),
        .RegW1(regw1), .DR1(dr1), .Reg_In1(reg_in1),
        .SR1(sr1), .SR2(sr2),
        .ReadReg1(b_rd1), .ReadReg2(b_rd2), .Ready(b_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        regw0 = 1'b0;
        regw1 = 1'b0;
    endtask

    // Both instances must hold Ready low for edges 1..31 and raise it on edge 32.
    task automatic sweep_ready(input string tag);
        for (int k = 1; k <= 32; k++) begin
            #1;
            check({tag, "_clr_rd1_a"}, a_rd1, 32'h0);
            check({tag, "_clr_rd1_b"}, b_rd1, 32'h0);
            step();
            check({tag, "_ready_a"}, {31'b0, a_ready}, {31'b0, k == 32});
            check({tag, "_ready_b"}, {31'b0, b_ready}, {31'b0, k == 32});
        end
    endtask

    initial begin
        rst = 1'b1;
        regw0 = 1'b0; dr0 = '0; reg_in0 = '0;
        regw1 = 1'b0; dr1 = '0; reg_in1 = '0;
        sr1 = '0; sr2 = '0;

        repeat (3) step();
        check("rst_ready_a", {31'b0, a_ready}, 32'h0);
        check("rst_ready_b", {31'b0, b_ready}, 32'h0);

        // Release with a write to entry 3 held through the sweep; it must be ignored.
        rst = 1'b0;
        regw0 = 1'b1; dr0 = 5'd3; reg_in0 = 32'h0000_00AB;
        sr1 = 5'd3;
        sweep_ready("sweep1");
        idle_writes();
        #1;
        check("clr_drop_a", a_rd1, 32'h0);
        check("clr_drop_b", b_rd1, 32'h3);

        sr1 = 5'd7; sr2 = 5'd0;
        #1;
        check("init7_a", a_rd1, 32'h0);
        check("init7_b", b_rd1, 32'h7);
        check("init0_a", a_rd2, 32'h0);
        check("init0_b", b_rd2, 32'h0);
        step();

        // Single write with same-cycle read.
        regw0 = 1'b1; dr0 = 5'd5; reg_in0 = 32'hDEAD_BEEF; sr1 = 5'd5;
        #1;
        check("byp_a", a_rd1, 32'hDEAD_BEEF);
        check("nobyp_old_b", b_rd1, 32'h5);
        step();
        idle_writes();
        #1;
        check("wr5_a", a_rd1, 32'hDEAD_BEEF);
        check("wr5_b", b_rd1, 32'hDEAD_BEEF);
        step();

        // Same-address collision: port 1 wins.
        regw0 = 1'b1; dr0 = 5'd9; reg_in0 = 32'h11;
        regw1 = 1'b1; dr1 = 5'd9; reg_in1 = 32'h22;
        sr1 = 5'd9; sr2 = 5'd9;
        #1;
        check("coll_byp1_a", a_rd1, 32'h22);
        check("coll_byp2_a", a_rd2, 32'h22);
        check("coll_old_b", b_rd1, 32'h9);
        step();
        idle_writes();
        #1;
        check("coll_wr_a", a_rd1, 32'h22);
        check("coll_wr_b", b_rd2, 32'h22);
        step();

        // Port 1 to hardwired entry 0 alongside port 0 to entry 6.
        regw1 = 1'b1; dr1 = 5'd0; reg_in1 = 32'hFFFF_FFFF;
        regw0 = 1'b1; dr0 = 5'd6; reg_in0 = 32'h66;
        sr2 = 5'd0; sr1 = 5'd6;
        #1;
        check("zero_same_a", a_rd2, 32'h0);
        check("zero_same_b", b_rd2, 32'h0);
        check("dual_byp_a", a_rd1, 32'h66);
        check("dual_old_b", b_rd1, 32'h6);
        step();
        idle_writes();
        #1;
        check("zero_next_a", a_rd2, 32'h0);
        check("zero_next_b", b_rd2, 32'h0);
        check("dual_wr_a", a_rd1, 32'h66);
        check("dual_wr_b", b_rd1, 32'h66);
        step();

        // Reset while running: Ready drops on the next edge.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("run_rst_a", {31'b0, a_ready}, 32'h0);
        check("run_rst_b", {31'b0, b_ready}, 32'h0);

        // Reset again at sweep index 20; sweep must restart from zero.
        repeat (20) step();
        check("mid_ready_a", {31'b0, a_ready}, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_a", {31'b0, a_ready}, 32'h0);
        check("mid_rst_b", {31'b0, b_ready}, 32'h0);
        sr1 = 5'd5; sr2 = 5'd9;
        sweep_ready("sweep2");
        #1;
        check("reswept5_a", a_rd1, 32'h0);
        check("reswept5_b", b_rd1, 32'h5);
        check("reswept9_a", a_rd2, 32'h0);
        check("reswept9_b", b_rd2, 32'h9);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
